// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder.
//   pad_state_t  : padder FSM states
//   BLOCK_W      : compression block width in bits
//   PAD_BYTE     : end-of-message marker byte
//   LEN_BYTE_POS : first byte of the 64-bit length field in the last block
package sha256_pkg;
  localparam int         BLOCK_W      = 512;
  localparam logic [7:0] PAD_BYTE     = 8'h80;
  localparam int         LEN_BYTE_POS = 56;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    PAD  = 3'd1,
    LEN  = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4
  } pad_state_t;
endpackage

// File: rtl/sha256_padder.sv
// sha256_padder: packs a byte stream big-endian into 512-bit blocks, appends
// the SHA-256 padding (0x80, zero fill, 64-bit bit length) and hands each
// block to the compression core with a start/finish handshake.
//   clock, reset      : clock, async active-low reset
//   in_data/in_valid/in_last/in_ready : byte stream in (ready only in FILL)
//   block             : current 512-bit block, byte k at [511-8k -: 8]
//   blk_start         : one-cycle request for the core to process block
//   blk_finish        : core finish flag (sampled in WAIT only)
//   msg_done          : one-cycle pulse after the final block completes
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] block,
  output logic               blk_start,
  input  logic               blk_finish,
  output logic               msg_done
);
  // bit position of the MSB of the 64-bit length field
  localparam int LEN_MSB = BLOCK_W - 8*LEN_BYTE_POS - 1;

  pad_state_t         state_q, state_d;
  pad_state_t         succ_q, succ_d;   // where WAIT resumes for non-final blocks
  logic               final_q, final_d; // block in flight is the last one
  logic [6:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               done_q, done_d;
  logic [63:0]        len64;

  assign len64     = 64'({count_q, 3'b000});
  assign in_ready  = (state_q == FILL);
  assign blk_start = (state_q == SEND);
  assign block     = buf_q;
  assign msg_done  = done_q;

  always_comb begin
    state_d = state_q;
    succ_d  = succ_q;
    final_d = final_q;
    idx_d   = idx_q;
    count_d = count_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          // ~idx selects byte lane 63-idx, i.e. big-endian placement
          buf_d[{~idx_q[5:0], 3'b000} +: 8] = in_data;
          idx_d   = idx_q + 7'd1;
          count_d = count_q + LEN_W'(1);
          if (idx_q == 7'd63) begin
            // full block goes out first; a last byte here defers PAD
            state_d = SEND;
            final_d = 1'b0;
            succ_d  = in_last ? PAD : FILL;
          end else if (in_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        buf_d[{~idx_q[5:0], 3'b000} +: 8] = PAD_BYTE;
        if (idx_q <= 7'(LEN_BYTE_POS - 1)) begin
          buf_d[LEN_MSB -: 64] = len64;
          final_d = 1'b1;
        end else begin
          // no room for the length: it goes into an extra block
          final_d = 1'b0;
          succ_d  = LEN;
        end
        state_d = SEND;
      end
      LEN: begin
        buf_d[LEN_MSB -: 64] = len64;
        final_d = 1'b1;
        state_d = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (blk_finish) begin
          buf_d = '0;
          idx_d = '0;
          if (final_q) begin
            done_d  = 1'b1;
            count_d = '0;
            state_d = FILL;
          end else begin
            state_d = succ_q;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      succ_q  <= FILL;
      final_q <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      succ_q  <= succ_d;
      final_q <= final_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed bench for sha256_padder with a behavioural core
// (programmable finish delay) and a scoreboard of expected padded blocks.
module tb_sha256_padder;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         fin;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [511:0] block;
  logic         blk_start;
  logic         blk_finish = 1'b0;
  logic         msg_done;

  int n_vec = 0;
  int n_err = 0;
  int core_delay = 2;
  int done_cnt = 0;
  exp_t exp_q[$];

  sha256_padder #(.LEN_W(32)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .block(block),
    .blk_start(blk_start), .blk_finish(blk_finish), .msg_done(msg_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference padding model: builds the padded byte string and splits it.
  task automatic push_expected(input bq_t m);
    bq_t p;
    logic [63:0] bl;
    int nb;
    exp_t e;
    p  = m;
    bl = 64'(m.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = p[64*b+k];
      e.fin = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // Entered and left at #1 after a posedge; in_valid stays high between bytes.
  task automatic send(input bq_t m, input bit push, input bit use_last);
    int cyc;
    bit ok;
    if (push) push_expected(m);
    for (int i = 0; i < m.size(); i++) begin
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = use_last && (i == m.size() - 1);
      cyc = 0;
      ok  = 1'b0;
      while (!ok && cyc < 2000) begin
        @(negedge clock);
        ok = in_ready;
        @(posedge clock);
        #1;
        cyc++;
      end
      if (!ok) chk("byte_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    chk("msg_done_timeout", 512'(done_cnt >= target), 512'd1);
    @(posedge clock);
    #1;
  endtask

  // Behavioural core: raises finish for one cycle core_delay cycles after start.
  initial begin
    forever begin
      @(negedge clock);
      if (blk_start === 1'b1) begin
        repeat (core_delay) @(posedge clock);
        #1 blk_finish = 1'b1;
        @(posedge clock);
        #1 blk_finish = 1'b0;
      end
    end
  end

  // Output monitor: block scoreboard, WAIT stability, msg_done timing.
  logic [511:0] held;
  bit in_wait = 0, cur_final = 0, done_exp = 0;
  always @(negedge clock) begin
    if (!reset) begin
      in_wait  = 0;
      done_exp = 0;
    end else begin
      chk("msg_done", 512'(msg_done), 512'(done_exp));
      if (msg_done === 1'b1) done_cnt++;
      done_exp = 0;
      if (blk_start === 1'b1) begin
        chk("in_ready_send", 512'(in_ready), 512'd0);
        if (exp_q.size() == 0) begin
          chk("extra_blk_start", 512'd1, 512'd0);
          cur_final = 0;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("block", block, e.blk);
          cur_final = e.fin;
        end
        held    = block;
        in_wait = 1;
      end else if (in_wait) begin
        chk("in_ready_wait", 512'(in_ready), 512'd0);
        chk("block_stable", block, held);
        if (blk_finish === 1'b1) begin
          in_wait  = 0;
          done_exp = cur_final;
        end
      end
    end
  end

  initial begin
    bq_t m;
    int nd = 0;
    #1 chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_blk_start", 512'(blk_start), 512'd0);
    chk("rst_msg_done", 512'(msg_done), 512'd0);
    chk("rst_block", block, 512'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    // "abc" with last-byte-to-start latency
    m = {8'h61, 8'h62, 8'h63};
    send(m, 1, 1);
    @(negedge clock);
    chk("pad_cycle_no_start", 512'(blk_start), 512'd0);
    @(negedge clock);
    chk("start_after_pad", 512'(blk_start), 512'd1);
    @(posedge clock);
    #1;
    wait_done(++nd);

    // 55 zero bytes: single block, length 0x1B8
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h00);
    send(m, 1, 1);
    wait_done(++nd);

    // 56 bytes: length spills into a second block
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
    send(m, 1, 1);
    wait_done(++nd);

    // 64 bytes of 0x61: full block then pad-only block
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'h61);
    send(m, 1, 1);
    wait_done(++nd);

    // backpressure: slow core, bytes held on the bus across WAIT
    core_delay = 100;
    m = {};
    for (int i = 0; i < 130; i++) m.push_back(8'($urandom_range(255)));
    send(m, 1, 1);
    wait_done(++nd);
    core_delay = 2;

    // reset at byte 30 of a 40-byte message
    m = {};
    for (int i = 0; i < 30; i++) m.push_back(8'(i + 8'h40));
    send(m, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_in_ready", 512'(in_ready), 512'd1);
    chk("midrst_blk_start", 512'(blk_start), 512'd0);
    chk("midrst_msg_done", 512'(msg_done), 512'd0);
    chk("midrst_block", block, 512'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    m = {8'h61, 8'h62, 8'h63};
    send(m, 1, 1);
    wait_done(++nd);

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);
    chk("msg_done_count", 512'(done_cnt), 512'(nd));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
